// File: rtl/wb_arbiter_2m_pkg.sv
// Shared constants for the two-master Wishbone arbiter.
//  - WB_DWIDTH / WB_SWIDTH / WB_AWIDTH : default bus widths
//  - ST_IDLE / ST_GNT0 / ST_GNT1       : grant FSM encodings
package wb_arbiter_2m_pkg;

    localparam int WB_DWIDTH = 32;
    localparam int WB_SWIDTH = WB_DWIDTH / 8;
    localparam int WB_AWIDTH = 30;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

endpackage

// File: rtl/wb_arbiter_2m_watchdog.sv
// wb_watchdog: counts consecutive cycles a granted strobe goes unacknowledged.
//  i_ck   clock
//  i_rb   asynchronous active-low reset
//  i_clr  clear the count (no grant, strobe low, or ack); has priority
//  i_en   granted strobe is pending this cycle
//  o_hit  this is cycle TO_CYC-1 of an unacknowledged strobe
// o_hit deliberately ignores i_clr: i_clr carries the slave ack, and the hit
// gates the slave strobe, which would otherwise close a combinational loop.
module wb_watchdog #(
    parameter int TO_CYC = 16
) (
    input  logic i_ck,
    input  logic i_rb,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam int CW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_hit = i_en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en) begin
            cnt_d = '0;
        end else if (o_hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_ck or negedge i_rb) begin
        if (!i_rb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter in front of one slave.
//  M0 = instruction fetch, M1 = load/store. Registered round-robin grant held
//  for the whole bus cycle; a watchdog aborts cycles the slave never acks.
//  i_ck / i_rb                      clock / async active-low reset
//  i_mX_cyc/stb/we/sel/adr/dat      master X request
//  o_mX_dat/ack/err                 master X response (err = 1-cycle timeout)
//  o_s_cyc/stb/we/sel/adr/dat       slave request (all zero when idle)
//  i_s_dat / i_s_ack                slave response
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int DWIDTH = WB_DWIDTH,
    parameter int SWIDTH = WB_SWIDTH,
    parameter int AWIDTH = WB_AWIDTH,
    parameter int TO_CYC = 16
) (
    input  logic              i_ck,
    input  logic              i_rb,
    input  logic              i_m0_cyc,
    input  logic              i_m0_stb,
    input  logic              i_m0_we,
    input  logic [SWIDTH-1:0] i_m0_sel,
    input  logic [AWIDTH-1:0] i_m0_adr,
    input  logic [DWIDTH-1:0] i_m0_dat,
    output logic [DWIDTH-1:0] o_m0_dat,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    input  logic              i_m1_cyc,
    input  logic              i_m1_stb,
    input  logic              i_m1_we,
    input  logic [SWIDTH-1:0] i_m1_sel,
    input  logic [AWIDTH-1:0] i_m1_adr,
    input  logic [DWIDTH-1:0] i_m1_dat,
    output logic [DWIDTH-1:0] o_m1_dat,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic              o_s_cyc,
    output logic              o_s_stb,
    output logic              o_s_we,
    output logic [SWIDTH-1:0] o_s_sel,
    output logic [AWIDTH-1:0] o_s_adr,
    output logic [DWIDTH-1:0] o_s_dat,
    input  logic [DWIDTH-1:0] i_s_dat,
    input  logic              i_s_ack
);

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;    // 1 = M1 owned the bus last

    logic gnt0, gnt1, gnt_any;
    logic own_stb;
    logic wd_hit, err;

    assign gnt0    = (state_q == ST_GNT0);
    assign gnt1    = (state_q == ST_GNT1);
    assign gnt_any = gnt0 | gnt1;
    assign own_stb = gnt1 ? i_m1_stb : (gnt0 & i_m0_stb);

    wb_watchdog #(.TO_CYC(TO_CYC)) u_wd (
        .i_ck  (i_ck),
        .i_rb  (i_rb),
        .i_clr (~gnt_any | ~own_stb | i_s_ack),
        .i_en  (gnt_any & own_stb),
        .o_hit (wd_hit)
    );

    // An ack landing on the expiry cycle wins, so ack and err never coincide.
    assign err = wd_hit & ~i_s_ack;

    // Request mux: idle drives zeros so the slave never sees stale fields.
    always_comb begin
        o_s_cyc = 1'b0;
        o_s_stb = 1'b0;
        o_s_we  = 1'b0;
        o_s_sel = '0;
        o_s_adr = '0;
        o_s_dat = '0;
        if (gnt0) begin
            o_s_cyc = i_m0_cyc;
            o_s_stb = i_m0_stb & ~wd_hit;
            o_s_we  = i_m0_we;
            o_s_sel = i_m0_sel;
            o_s_adr = i_m0_adr;
            o_s_dat = i_m0_dat;
        end else if (gnt1) begin
            o_s_cyc = i_m1_cyc;
            o_s_stb = i_m1_stb & ~wd_hit;
            o_s_we  = i_m1_we;
            o_s_sel = i_m1_sel;
            o_s_adr = i_m1_adr;
            o_s_dat = i_m1_dat;
        end
    end

    // Return demux: acks arriving while idle (abandoned beats) go nowhere.
    assign o_m0_ack = i_s_ack & gnt0;
    assign o_m1_ack = i_s_ack & gnt1;
    assign o_m0_err = err & gnt0;
    assign o_m1_err = err & gnt1;
    assign o_m0_dat = gnt0 ? i_s_dat : '0;
    assign o_m1_dat = gnt1 ? i_s_dat : '0;

    // Grant FSM. Owners always pass through IDLE, giving one dead cycle
    // between different masters.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
                    state_d = ST_GNT0;
                    last_d  = 1'b0;
                end else if (i_m1_cyc) begin
                    state_d = ST_GNT1;
                    last_d  = 1'b1;
                end
            end
            ST_GNT0: if (!i_m0_cyc || err) state_d = ST_IDLE;
            ST_GNT1: if (!i_m1_cyc || err) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_ck or negedge i_rb) begin
        if (!i_rb) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
